// File: rtl/ddr_cmd_data_driver.sv
// ddr_cmd_data_driver: DDR4 command/address encoder and write-data engine; CA parity enabled by DDR_CA_PARITY_EN
module ddr_cmd_data_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int BG_WIDTH   = 2,
  parameter int BA_WIDTH   = 2,
  parameter int ROW_WIDTH  = 18,
  parameter int COL_WIDTH  = 10,
  parameter int BL         = 8,
  parameter int PREAMBLE   = 1,
  parameter int WL_W       = 5
) (
  input  logic                     clock_t,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_code,
  input  logic [BG_WIDTH-1:0]      cmd_bg,
  input  logic [BA_WIDTH-1:0]      cmd_ba,
  input  logic [ROW_WIDTH-1:0]     cmd_row,
  input  logic [COL_WIDTH-1:0]     cmd_col,
  input  logic [BL*DATA_WIDTH-1:0] cmd_wdata,
  input  logic [WL_W-1:0]          wl,
  output logic                     cs_n,
  output logic                     act_n,
  output logic                     ras_n_a16,
  output logic                     cas_n_a15,
  output logic                     we_n_a14,
  output logic                     bc_n_a12,
  output logic                     ap_a10,
  output logic                     addr17,
  output logic                     addr13,
  output logic                     addr11,
  output logic [9:0]               addr9_0,
  output logic [BG_WIDTH-1:0]      bg_addr,
  output logic [BA_WIDTH-1:0]      ba_addr,
  output logic [DATA_WIDTH-1:0]    dq_out,
  output logic                     dq_oe,
  output logic                     dqs_t,
  output logic                     dqs_c,
  output logic                     par,
  output logic                     wr_busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_BURST = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam int BW = (BL > 1) ? $clog2(BL) : 1;
  logic [2:0] state_q, state_d;
  logic [WL_W-1:0] cnt_q, cnt_d, wl_eff;
  logic [BL-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0] beat;
  logic [17:0] row18, a_d, a_q;
  logic [9:0] col10;
  logic cs_d, cs_q, act_d, act_q;
  logic [BG_WIDTH-1:0] bg_d, bg_q;
  logic [BA_WIDTH-1:0] ba_d, ba_q;
  logic accept, wr_accept;
  assign row18 = 18'(cmd_row);
  assign col10 = 10'(cmd_col);
  assign cmd_ready = reset_n && !(cmd_code == 4'd3 && state_q != S_IDLE && state_q != S_POST);
  assign accept = cmd_valid && cmd_ready;
  assign wr_accept = accept && cmd_code == 4'd3;
  // Encode the accepted command into next-cycle pin values; DES when nothing is accepted
  always_comb begin
    cs_d = 1'b1;
    act_d = 1'b1;
    a_d = '1;
    bg_d = '1;
    ba_d = '1;
    if (accept) begin
      case (cmd_code)
        4'd0: begin
          cs_d = 1'b0;
          act_d = 1'b0;
          a_d = row18;
          bg_d = cmd_bg;
          ba_d = cmd_ba;
        end
        4'd1: begin
          cs_d = 1'b0;
          a_d[16:14] = 3'b010;
          a_d[10] = 1'b0;
          bg_d = cmd_bg;
          ba_d = cmd_ba;
        end
        4'd2, 4'd3: begin
          cs_d = 1'b0;
          a_d[16:14] = {2'b10, ~cmd_code[0]};
          a_d[12] = (BL == 8);
          a_d[10] = 1'b0;
          a_d[9:0] = col10;
          bg_d = cmd_bg;
          ba_d = cmd_ba;
        end
        4'd4: begin
          cs_d = 1'b0;
          a_d[16:14] = 3'b000;
          a_d[17] = row18[17];
          a_d[13:0] = row18[13:0];
          bg_d = cmd_bg;
          ba_d = cmd_ba;
        end
        4'd5: begin
          cs_d = 1'b0;
          a_d[16:14] = 3'b001;
        end
        4'd6: begin
          cs_d = 1'b0;
          a_d[16:14] = 3'b110;
        end
        4'd8: cs_d = 1'b0;
        default: ;
      endcase
    end
  end
  // Register the command/address pins so each command is driven for exactly one cycle
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      cs_q <= 1'b1;
      act_q <= 1'b1;
      a_q <= '1;
      bg_q <= '1;
      ba_q <= '1;
    end else begin
      cs_q <= cs_d;
      act_q <= act_d;
      a_q <= a_d;
      bg_q <= bg_d;
      ba_q <= ba_d;
    end
  end
`ifdef DDR_CA_PARITY_EN
  logic par_q;
  // Even parity registered alongside the pins it covers; cs_n is not part of it
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) par_q <= 1'b0;
    else par_q <= ^{act_d, a_d, bg_d, ba_d};
  end
  assign par = par_q;
`else
  assign par = 1'b0;
`endif
  assign cs_n = cs_q;
  assign act_n = act_q;
  assign addr17 = a_q[17];
  assign ras_n_a16 = a_q[16];
  assign cas_n_a15 = a_q[15];
  assign we_n_a14 = a_q[14];
  assign addr13 = a_q[13];
  assign bc_n_a12 = a_q[12];
  assign addr11 = a_q[11];
  assign ap_a10 = a_q[10];
  assign addr9_0 = a_q[9:0];
  assign bg_addr = bg_q;
  assign ba_addr = ba_q;
  assign wl_eff = (wl < WL_W'(PREAMBLE)) ? WL_W'(PREAMBLE) : wl;
  // Write engine sequencing: wait out the latency, then preamble, burst beats and one postamble cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_WAIT: begin
        state_d = (cnt_q == '0) ? S_PRE : S_WAIT;
        cnt_d = (cnt_q == '0) ? WL_W'(PREAMBLE - 1) : cnt_q - 1'b1;
      end
      S_PRE: begin
        state_d = (cnt_q == '0) ? S_BURST : S_PRE;
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      end
      S_BURST: begin
        state_d = (cnt_q == WL_W'(BL - 1)) ? S_POST : S_BURST;
        cnt_d = (cnt_q == WL_W'(BL - 1)) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_accept) begin
      state_d = (wl_eff > WL_W'(PREAMBLE)) ? S_WAIT : S_PRE;
      cnt_d = (wl_eff > WL_W'(PREAMBLE)) ? wl_eff - WL_W'(PREAMBLE) - 1'b1 : WL_W'(PREAMBLE - 1);
    end
  end
  // Write engine state and the burst captured at CAS_W acceptance
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (wr_accept) wdata_q <= cmd_wdata;
    end
  end
  assign beat = cnt_q[BW-1:0];
  assign dq_oe = state_q == S_BURST;
  assign dq_out = dq_oe ? wdata_q[beat] : '0;
  assign dqs_t = dq_oe ? ~beat[0] : !(state_q == S_PRE || state_q == S_POST);
  assign dqs_c = dq_oe ? beat[0] : 1'b1;
  assign wr_busy = state_q != S_IDLE;
endmodule

// File: tb/tb_ddr_cmd_data_driver.sv
// tb_ddr_cmd_data_driver: scoreboard bench for the DDR4 command/data driver
module tb_ddr_cmd_data_driver;
`ifdef DDR_CA_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int PRE_CYC = 1;
  logic clock_t = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [3:0] cmd_code = '0;
  logic [1:0] cmd_bg = '0, cmd_ba = '0;
  logic [17:0] cmd_row = '0;
  logic [9:0] cmd_col = '0;
  logic [63:0] cmd_wdata = '0;
  logic [4:0] wl = '0;
  logic cmd_ready, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bc_n_a12, ap_a10, addr17, addr13, addr11;
  logic [9:0] addr9_0;
  logic [1:0] bg_addr, ba_addr;
  logic [7:0] dq_out;
  logic dq_oe, dqs_t, dqs_c, par, wr_busy;
  logic [23:0] pins;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  typedef struct {int cyc; logic [23:0] pins;} cmd_t;
  typedef struct {int cyc; logic oe; logic [7:0] dq; logic t; logic c;} dat_t;
  cmd_t cq[$];
  dat_t dq_q[$];

  ddr_cmd_data_driver dut (
    .clock_t(clock_t), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_wdata(cmd_wdata), .wl(wl), .cs_n(cs_n), .act_n(act_n), .ras_n_a16(ras_n_a16),
    .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14), .bc_n_a12(bc_n_a12), .ap_a10(ap_a10),
    .addr17(addr17), .addr13(addr13), .addr11(addr11), .addr9_0(addr9_0), .bg_addr(bg_addr),
    .ba_addr(ba_addr), .dq_out(dq_out), .dq_oe(dq_oe), .dqs_t(dqs_t), .dqs_c(dqs_c),
    .par(par), .wr_busy(wr_busy)
  );

  assign pins = {cs_n, act_n, addr17, ras_n_a16, cas_n_a15, we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0, bg_addr, ba_addr};

  always #5 clock_t = ~clock_t;
  always @(posedge clock_t) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clock_t) begin
    cmd_t e;
    if (reset_n) begin
      if (!cs_n) begin
        if (cq.size() == 0) chk("cmd_unexpected", pins, 24'hFFFFFF);
        else begin
          e = cq.pop_front();
          chk("cmd_cycle", cyc, e.cyc);
          chk("cmd_pins", pins, e.pins);
          chk("cmd_par", par, PAR_EN ? ^e.pins[22:0] : 1'b0);
        end
      end else begin
        chk("des_pins", pins, 24'hFFFFFF);
        chk("des_par", par, PAR_EN ? 1'b1 : 1'b0);
      end
    end
  end

  always @(negedge clock_t) begin
    dat_t d;
    if (reset_n && (dq_oe || !dqs_t || !dqs_c)) begin
      if (dq_q.size() == 0) chk("dq_unexpected", {dq_oe, dqs_t, dqs_c}, 3'b011);
      else begin
        d = dq_q.pop_front();
        chk("dq_cycle", cyc, d.cyc);
        chk("dq_beat", {dq_oe, dq_out, dqs_t, dqs_c}, {d.oe, d.dq, d.t, d.c});
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_pins"}, pins, 24'hFFFFFF);
    chk({tag, "_dq"}, {dq_oe, dq_out}, 9'h000);
    chk({tag, "_dqs"}, {dqs_t, dqs_c}, 2'b11);
    chk({tag, "_par"}, par, 1'b0);
    chk({tag, "_busy"}, wr_busy, 1'b0);
    chk({tag, "_ready"}, cmd_ready, 1'b0);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clock_t);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] code, input logic [1:0] bg, input logic [1:0] ba,
                       input logic [17:0] row, input logic [9:0] col, input logic [63:0] wd,
                       input logic [4:0] wlv, input bit has_exp, input logic [23:0] exp, output int acc);
    bit rdy = 1'b0;
    int n = 0;
    int we;
    cmd_code = code; cmd_bg = bg; cmd_ba = ba; cmd_row = row; cmd_col = col; cmd_wdata = wd; wl = wlv;
    cmd_valid = 1'b1;
    while (!rdy && n < 100) begin
      @(negedge clock_t);
      rdy = cmd_ready;
      @(posedge clock_t);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    acc = cyc;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: cmd_ready got 0 expected 1 within 100 cycles (code %0d)", code);
    end else begin
      if (has_exp) cq.push_back('{acc, exp});
      if (code == 4'd3) begin
        we = (int'(wlv) < PRE_CYC) ? PRE_CYC : int'(wlv);
        for (int p = PRE_CYC; p > 0; p--) dq_q.push_back('{acc + we - p, 1'b0, 8'h00, 1'b0, 1'b1});
        for (int i = 0; i < 8; i++) dq_q.push_back('{acc + we + i, 1'b1, wd[i*8 +: 8], ~i[0], i[0]});
        dq_q.push_back('{acc + we + 8, 1'b0, 8'h00, 1'b0, 1'b1});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no end, expected finish");
    $fatal(1);
  end

  initial begin
    int k, k1, k2, k3;
    repeat (3) @(posedge clock_t);
    @(negedge clock_t);
    check_reset("reset");
    #1 reset_n = 1'b1;
    @(posedge clock_t);
    #1;
    chk("ready_after_reset", cmd_ready, 1'b1);
    idle(2);
    issue(4'd0, 2'd2, 2'd1, 18'h1A5A3, 10'h000, 64'h0, 5'd0, 1'b1, {1'b0, 1'b0, 18'h1A5A3, 2'd2, 2'd1}, k);
    issue(4'd1, 2'd1, 2'd3, 18'h0, 10'h000, 64'h0, 5'd0, 1'b1, {1'b0, 1'b1, 18'h2BBFF, 2'd1, 2'd3}, k);
    issue(4'd2, 2'd3, 2'd0, 18'h0, 10'h2AA, 64'h0, 5'd0, 1'b1, {1'b0, 1'b1, 18'h37AAA, 2'd3, 2'd0}, k);
    issue(4'd4, 2'd1, 2'd0, 18'h0ABCD, 10'h000, 64'h0, 5'd0, 1'b1, {1'b0, 1'b1, 18'h02BCD, 2'd1, 2'd0}, k);
    idle(1);
    issue(4'd5, 2'd0, 2'd1, 18'h0, 10'h000, 64'h0, 5'd0, 1'b1, {1'b0, 1'b1, 18'h27FFF, 2'd3, 2'd3}, k);
    issue(4'd6, 2'd2, 2'd0, 18'h0, 10'h000, 64'h0, 5'd0, 1'b1, {1'b0, 1'b1, 18'h3BFFF, 2'd3, 2'd3}, k);
    issue(4'd8, 2'd1, 2'd1, 18'h12345, 10'h155, 64'h0, 5'd0, 1'b1, {1'b0, 1'b1, 18'h3FFFF, 2'd3, 2'd3}, k);
    issue(4'd12, 2'd1, 2'd1, 18'h12345, 10'h155, 64'h0, 5'd0, 1'b0, 24'h0, k);
    issue(4'd0, 2'd0, 2'd0, 18'h00001, 10'h000, 64'h0, 5'd0, 1'b1, {1'b0, 1'b0, 18'h00001, 2'd0, 2'd0}, k);
    idle(2);
    issue(4'd3, 2'd0, 2'd2, 18'h0, 10'h155, 64'h8877665544332211, 5'd9, 1'b1, {1'b0, 1'b1, 18'h33955, 2'd0, 2'd2}, k1);
    chk("busy_at_t0", wr_busy, 1'b1);
    issue(4'd1, 2'd1, 2'd3, 18'h0, 10'h000, 64'h0, 5'd0, 1'b1, {1'b0, 1'b1, 18'h2BBFF, 2'd1, 2'd3}, k);
    chk("pre_during_write_accept", k, k1 + 1);
    idle(2);
    cmd_code = 4'd3;
    #1 chk("casw_ready_while_busy", cmd_ready, 1'b0);
    issue(4'd3, 2'd0, 2'd2, 18'h0, 10'h155, 64'hF0E1D2C3B4A59687, 5'd0, 1'b1, {1'b0, 1'b1, 18'h33955, 2'd0, 2'd2}, k2);
    chk("casw2_accept_cycle", k2, k1 + 18);
    idle(15);
    chk("busy_after_writes", wr_busy, 1'b0);
    issue(4'd3, 2'd0, 2'd2, 18'h0, 10'h155, 64'h0123456789ABCDEF, 5'd2, 1'b1, {1'b0, 1'b1, 18'h33955, 2'd0, 2'd2}, k3);
    while (cyc < k3 + 5) begin
      @(posedge clock_t);
      #1;
    end
    chk("mid_burst_beat3", {dq_oe, dq_out}, {1'b1, 8'h89});
    #1 reset_n = 1'b0;
    cq.delete();
    dq_q.delete();
    #1 check_reset("mid_burst_reset");
    repeat (3) @(posedge clock_t);
    @(negedge clock_t);
    #1 reset_n = 1'b1;
    idle(20);
    chk("busy_after_release", wr_busy, 1'b0);
    chk("cmd_queue_drained", cq.size(), 0);
    chk("dq_queue_drained", dq_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
